// File: rtl/ex_pkg.sv
// ex_pkg
//   Shared definitions for the execute stage: ALU operation codes, bit positions
//   inside the EX_EX / EX_WB / EX_M control bundles, multiplier FSM state codes
//   and a small forwarding-match helper.
//   Optional feature macro used by the importing files: EX_MUL_EN.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SUB = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  // EX_EX control bundle
  localparam int EX_ALU_OP_LSB = 0;
  localparam int EX_ALU_OP_MSB = 2;
  localparam int EX_ALU_SRC    = 3;
  localparam int EX_REG_DST    = 4;

  // EX_WB / EX_M control bundles
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;

  // Iterative multiplier FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A later stage supplies an operand only if it really writes a register and
  // that register is not r0 (r0 always reads as the register file value).
  function automatic logic fwd_hit(input logic       reg_write,
                                   input logic [4:0] src_rd,
                                   input logic [4:0] rs);
    return reg_write && (src_rd != 5'd0) && (src_rd == rs);
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// mul_iter
//   Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle,
//   N = WIDTH/MUL_BITS steps. Only compiled when EX_MUL_EN is defined.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-low reset
//     start    in   accepted in IDLE: latches op_a/op_b, begins stepping
//     op_a     in   multiplicand (WIDTH)
//     op_b     in   multiplier (WIDTH)
//     busy     out  high while stepping (N cycles)
//     done     out  high for one cycle after the last step; product valid
//     product  out  low WIDTH bits of op_a*op_b
`ifdef EX_MUL_EN
module mul_iter
  import ex_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int N     = WIDTH / MUL_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Each step adds multiplicand * (low MUL_BITS of multiplier) and shifts both
  // registers; bits shifted out of the multiplicand only affect product bits
  // above WIDTH, which are discarded.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d    = acc_q + (mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]));
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = (state_q == ST_MUL);
  assign done    = (state_q == ST_DONE);
  assign product = acc_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage: operand forwarding, ALU, destination select and the EX/MEM
//   pipeline register. With EX_MUL_EN defined, alu_op MUL (with RegWrite) runs
//   on mul_iter and holds ex_stall high for N+1 cycles while EX/MEM takes
//   bubbles; without it, MUL is a one-cycle op producing 0 and ex_stall is 0.
//   Ports:
//     clk, rst                        clock; synchronous active-low reset
//     EX_WB, EX_M, EX_EX              control from ID/EX
//     EX_SRC_A, EX_SRC_B, EX_SE       register operands, sign-extended immediate
//     EX_rs, EX_rt, EX_rd             register numbers
//     mem_reg_write/mem_rd/mem_alu_out  EX/MEM forwarding source
//     wb_reg_write/wb_rd/wb_data        MEM/WB forwarding source
//     ex_stall                        combinational stall request
//     MEM_WB, MEM_M, MEM_ALU_OUT, MEM_WRITE_DATA, MEM_rd, MEM_zero  EX/MEM register
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       EX_WB,
  input  logic [1:0]       EX_M,
  input  logic [4:0]       EX_EX,
  input  logic [WIDTH-1:0] EX_SRC_A,
  input  logic [WIDTH-1:0] EX_SRC_B,
  input  logic [WIDTH-1:0] EX_SE,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic [4:0]       EX_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_alu_out,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_stall,
  output logic [1:0]       MEM_WB,
  output logic [1:0]       MEM_M,
  output logic [WIDTH-1:0] MEM_ALU_OUT,
  output logic [WIDTH-1:0] MEM_WRITE_DATA,
  output logic [4:0]       MEM_rd,
  output logic             MEM_zero
);

  if ((WIDTH % MUL_BITS) != 0) begin : g_bad_mul_bits
    $error("ex_stage: MUL_BITS must divide WIDTH");
  end

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_result, ex_result;
  logic [4:0]       dest;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [1:0]       mem_wb_q,         mem_wb_d;
  logic [1:0]       mem_m_q,          mem_m_d;
  logic [WIDTH-1:0] mem_alu_out_q,    mem_alu_out_d;
  logic [WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic [4:0]       mem_rd_q,         mem_rd_d;
  logic             mem_zero_q,       mem_zero_d;

  assign alu_op = EX_EX[EX_ALU_OP_MSB:EX_ALU_OP_LSB];

  // The EX/MEM source is younger than MEM/WB, so it wins when both match.
  always_comb begin
    fwd_a = EX_SRC_A;
    if (fwd_hit(mem_reg_write, mem_rd, EX_rs)) begin
      fwd_a = mem_alu_out;
    end else if (fwd_hit(wb_reg_write, wb_rd, EX_rs)) begin
      fwd_a = wb_data;
    end
    fwd_b = EX_SRC_B;
    if (fwd_hit(mem_reg_write, mem_rd, EX_rt)) begin
      fwd_b = mem_alu_out;
    end else if (fwd_hit(wb_reg_write, wb_rd, EX_rt)) begin
      fwd_b = wb_data;
    end
    alu_b = EX_EX[EX_ALU_SRC] ? EX_SE : fwd_b;
    dest  = EX_EX[EX_REG_DST] ? EX_rd : EX_rt;
  end

  // Single-cycle ALU; MUL produces 0 here and is supplied by mul_iter when enabled.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_ADD: alu_result = fwd_a + alu_b;
      ALU_XOR: alu_result = fwd_a ^ alu_b;
      ALU_NOR: alu_result = ~(fwd_a | alu_b);
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_SUB: alu_result = fwd_a - alu_b;
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic mul_req;

  // A MUL that writes no register has no visible effect, so it never stalls.
  assign mul_req   = (alu_op == ALU_MUL) && EX_WB[WB_REG_WRITE];
  assign mul_start = rst && mul_req && !mul_busy && !mul_done;

  mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (fwd_a),
    .op_b    (alu_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // The DONE cycle does not stall: ID/EX may advance while EX/MEM takes the product.
  assign ex_stall = mul_start || (rst && mul_busy);
`else
  assign mul_start   = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign ex_stall    = 1'b0;
`endif

  assign ex_result = mul_done ? mul_product : alu_result;

  // While the multiplier is starting or stepping, EX/MEM receives a bubble:
  // control cleared, data fields hold their last value.
  always_comb begin
    mem_wb_d         = mem_wb_q;
    mem_m_d          = mem_m_q;
    mem_alu_out_d    = mem_alu_out_q;
    mem_write_data_d = mem_write_data_q;
    mem_rd_d         = mem_rd_q;
    mem_zero_d       = mem_zero_q;
    if (mul_start || mul_busy) begin
      mem_wb_d = '0;
      mem_m_d  = '0;
    end else begin
      mem_wb_d         = EX_WB;
      mem_m_d          = EX_M;
      mem_alu_out_d    = ex_result;
      mem_write_data_d = fwd_b;
      mem_rd_d         = dest;
      mem_zero_d       = (ex_result == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wb_q         <= '0;
      mem_m_q          <= '0;
      mem_alu_out_q    <= '0;
      mem_write_data_q <= '0;
      mem_rd_q         <= '0;
      mem_zero_q       <= 1'b0;
    end else begin
      mem_wb_q         <= mem_wb_d;
      mem_m_q          <= mem_m_d;
      mem_alu_out_q    <= mem_alu_out_d;
      mem_write_data_q <= mem_write_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_zero_q       <= mem_zero_d;
    end
  end

  assign MEM_WB         = mem_wb_q;
  assign MEM_M          = mem_m_q;
  assign MEM_ALU_OUT    = mem_alu_out_q;
  assign MEM_WRITE_DATA = mem_write_data_q;
  assign MEM_rd         = mem_rd_q;
  assign MEM_zero       = mem_zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Self-checking bench for ex_stage: a table of directed vectors, randomized
//   single-cycle traffic against a behavioural model, and hand-written
//   multi-cycle sequences for reset and (with EX_MUL_EN) the iterative MUL.
module tb_ex_stage;

  localparam int WIDTH    = 32;
  localparam int MUL_BITS = 1;
  localparam int N_STEPS  = WIDTH / MUL_BITS;
`ifdef EX_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [4:0] ex;
    word_t      src_a;
    word_t      src_b;
    word_t      se;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       mrw;
    logic [4:0] mrd;
    word_t      mout;
    logic       wrw;
    logic [4:0] wrd;
    word_t      wdata;
  } in_t;

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    word_t      alu_out;
    word_t      wr_data;
    logic [4:0] rd;
    logic       zero;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] EX_WB, EX_M;
  logic [4:0] EX_EX, EX_rs, EX_rt, EX_rd, mem_rd, wb_rd, MEM_rd;
  word_t      EX_SRC_A, EX_SRC_B, EX_SE, mem_alu_out, wb_data;
  logic       mem_reg_write, wb_reg_write, ex_stall, MEM_zero;
  logic [1:0] MEM_WB, MEM_M;
  word_t      MEM_ALU_OUT, MEM_WRITE_DATA;

  int checks   = 0;
  int failures = 0;

  ex_stage #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .rst(rst),
    .EX_WB(EX_WB), .EX_M(EX_M), .EX_EX(EX_EX),
    .EX_SRC_A(EX_SRC_A), .EX_SRC_B(EX_SRC_B), .EX_SE(EX_SE),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_out(mem_alu_out),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall),
    .MEM_WB(MEM_WB), .MEM_M(MEM_M), .MEM_ALU_OUT(MEM_ALU_OUT),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_rd(MEM_rd), .MEM_zero(MEM_zero)
  );

  always #5 clk = ~clk;

  // Hard time limit so a hung sequence still reports.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input in_t s);
    EX_WB         = s.wb;
    EX_M          = s.m;
    EX_EX         = s.ex;
    EX_SRC_A      = s.src_a;
    EX_SRC_B      = s.src_b;
    EX_SE         = s.se;
    EX_rs         = s.rs;
    EX_rt         = s.rt;
    EX_rd         = s.rd;
    mem_reg_write = s.mrw;
    mem_rd        = s.mrd;
    mem_alu_out   = s.mout;
    wb_reg_write  = s.wrw;
    wb_rd         = s.wrd;
    wb_data       = s.wdata;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string name, input out_t e);
    checkOutput($sformatf("%s/MEM_WB", name),         64'(MEM_WB),         64'(e.wb));
    checkOutput($sformatf("%s/MEM_M", name),          64'(MEM_M),          64'(e.m));
    checkOutput($sformatf("%s/MEM_ALU_OUT", name),    64'(MEM_ALU_OUT),    64'(e.alu_out));
    checkOutput($sformatf("%s/MEM_WRITE_DATA", name), 64'(MEM_WRITE_DATA), 64'(e.wr_data));
    checkOutput($sformatf("%s/MEM_rd", name),         64'(MEM_rd),         64'(e.rd));
    checkOutput($sformatf("%s/MEM_zero", name),       64'(MEM_zero),       64'(e.zero));
  endtask

  // Behavioural reference for one non-stalling instruction.
  function automatic out_t model(input in_t s);
    word_t       a, b, opb, r;
    logic [63:0] prod;
    out_t        o;
    a = s.src_a;
    if (s.mrw && s.mrd != 0 && s.mrd == s.rs)      a = s.mout;
    else if (s.wrw && s.wrd != 0 && s.wrd == s.rs) a = s.wdata;
    b = s.src_b;
    if (s.mrw && s.mrd != 0 && s.mrd == s.rt)      b = s.mout;
    else if (s.wrw && s.wrd != 0 && s.wrd == s.rt) b = s.wdata;
    opb = s.ex[3] ? s.se : b;
    case (s.ex[2:0])
      3'd0: r = a & opb;
      3'd1: r = a | opb;
      3'd2: r = a + opb;
      3'd3: r = a ^ opb;
      3'd4: r = ~(a | opb);
      3'd5: r = ($signed(a) < $signed(opb)) ? word_t'(1) : word_t'(0);
      3'd6: r = a - opb;
      default: begin
        prod = 64'(a) * 64'(opb);
        r    = (MUL_ON && s.wb[1]) ? prod[WIDTH-1:0] : word_t'(0);
      end
    endcase
    o.wb      = s.wb;
    o.m       = s.m;
    o.alu_out = r;
    o.wr_data = b;
    o.rd      = s.ex[4] ? s.rd : s.rt;
    o.zero    = (r == 0);
    return o;
  endfunction

  function automatic in_t randIn();
    in_t s;
    s.wb    = 2'($urandom);
    s.m     = 2'($urandom);
    s.ex    = 5'($urandom);
    s.src_a = $urandom;
    s.src_b = ($urandom_range(0, 3) == 0) ? s.src_a : $urandom;
    s.se    = ($urandom_range(0, 1) == 0) ? word_t'($urandom_range(0, 15)) : $urandom;
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom);
    s.mrw   = 1'($urandom);
    s.mrd   = 5'($urandom_range(0, 3));
    s.mout  = $urandom;
    s.wrw   = 1'($urandom);
    s.wrd   = 5'($urandom_range(0, 3));
    s.wdata = $urandom;
    if (MUL_ON && s.ex[2:0] == 3'b111) s.wb[1] = 1'b0;
    return s;
  endfunction

  function automatic vec_t mkv(input string name, input logic [1:0] wb, input logic [1:0] m,
                               input logic [4:0] ex, input word_t a, input word_t b,
                               input word_t se, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic mrw, input logic [4:0] mrd,
                               input word_t mout, input logic wrw, input logic [4:0] wrd,
                               input word_t wdat, input word_t e_alu, input word_t e_wd,
                               input logic [4:0] e_rd, input logic e_zero);
    vec_t v;
    v.name = name;
    v.in   = '{wb: wb, m: m, ex: ex, src_a: a, src_b: b, se: se, rs: rs, rt: rt, rd: rd,
               mrw: mrw, mrd: mrd, mout: mout, wrw: wrw, wrd: wrd, wdata: wdat};
    v.exp  = '{wb: wb, m: m, alu_out: e_alu, wr_data: e_wd, rd: e_rd, zero: e_zero};
    return v;
  endfunction

  // Operands with no forwarding, rs=1 rt=2 rd=3, destination rt.
  function automatic vec_t mkSimple(input string name, input logic [4:0] ex, input word_t a,
                                    input word_t b, input word_t e_alu, input logic e_zero);
    return mkv(name, 2'b10, 2'b00, ex, a, b, 0, 5'd1, 5'd2, 5'd3,
               1'b0, 5'd0, 0, 1'b0, 5'd0, 0, e_alu, b, 5'd2, e_zero);
  endfunction

`ifdef EX_MUL_EN
  // Runs one MUL after a known ADD (1+2=3) and checks stall length, bubbles,
  // operand latching while sources change, and the final EX/MEM contents.
  task automatic runMul(input string name, input word_t a, input word_t b, input word_t prod);
    in_t s;
    int  stall_cycles;
    bit  released;
    s = '0;
    s.wb = 2'b10; s.ex = 5'b10010; s.src_a = 1; s.src_b = 2; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd9;
    applyStimulus(s);
    @(negedge clk);
    checkOutput({name, "/pre_add"}, 64'(MEM_ALU_OUT), 64'd3);
    s.ex = 5'b10111; s.src_a = a; s.src_b = b; s.rs = 5'd3; s.rt = 5'd4; s.rd = 5'd12;
    applyStimulus(s);
    #1;
    checkOutput({name, "/stall_start"}, 64'(ex_stall), 64'd1);
    stall_cycles = 1;
    released     = 1'b0;
    for (int c = 0; c < 4 * N_STEPS + 8 && !released; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s/bubble_wb%0d", name, c), 64'(MEM_WB), 64'd0);
      checkOutput($sformatf("%s/bubble_m%0d", name, c), 64'(MEM_M), 64'd0);
      checkOutput($sformatf("%s/hold_out%0d", name, c), 64'(MEM_ALU_OUT), 64'd3);
      if (ex_stall) stall_cycles++;
      else          released = 1'b1;
      if (c == 0) begin
        s.src_a = 32'hDEAD_BEEF; s.src_b = 32'h1234_5678;
        s.mrw = 1'b1; s.mrd = 5'd3; s.mout = 32'hCAFE_F00D;
        applyStimulus(s);
      end
    end
    checkOutput({name, "/stall_released"}, 64'(released), 64'd1);
    checkOutput({name, "/stall_cycles"}, 64'(stall_cycles), 64'(N_STEPS + 1));
    @(negedge clk);
    checkOutput({name, "/product"}, 64'(MEM_ALU_OUT), 64'(prod));
    checkOutput({name, "/wb"}, 64'(MEM_WB), 64'd2);
    checkOutput({name, "/rd"}, 64'(MEM_rd), 64'd12);
    checkOutput({name, "/zero"}, 64'(MEM_zero), 64'(prod == 0));
    s = '0;
    applyStimulus(s);
  endtask
`endif

  initial begin
    vec_t tbl[$];
    in_t  s;
    out_t e;

    // Directed vectors: name, wb, m, ex, A, B, SE, rs, rt, rd, mrw, mrd, mout,
    // wrw, wrd, wdata, exp alu, exp write data, exp rd, exp zero.
    tbl.push_back(mkv("add_fwd_mem", 2'b10, 2'b00, 5'b11010, 11, 22, 7, 5'd3, 5'd5, 5'd9,
                      1'b1, 5'd3, 100, 1'b0, 5'd0, 0, 107, 22, 5'd9, 1'b0));
    tbl.push_back(mkv("fwd_b_mem_prio", 2'b11, 2'b10, 5'b00001, 0, 5, 0, 5'd1, 5'd4, 5'd0,
                      1'b1, 5'd4, 20, 1'b1, 5'd4, 30, 20, 20, 5'd4, 1'b0));
    tbl.push_back(mkv("fwd_r0", 2'b10, 2'b00, 5'b10010, 5, 6, 0, 5'd0, 5'd0, 5'd7,
                      1'b1, 5'd0, 100, 1'b1, 5'd0, 200, 11, 6, 5'd7, 1'b0));
    tbl.push_back(mkv("fwd_wb_only", 2'b10, 2'b00, 5'b00011, 1, 2, 0, 5'd2, 5'd8, 5'd0,
                      1'b1, 5'd8, 100, 1'b1, 5'd2, 30, 122, 100, 5'd8, 1'b0));
    tbl.push_back(mkv("fwd_mem_rw0", 2'b10, 2'b00, 5'b01110, 0, 3, 15, 5'd6, 5'd1, 5'd0,
                      1'b0, 5'd6, 99, 1'b1, 5'd6, 40, 25, 3, 5'd1, 1'b0));
    tbl.push_back(mkSimple("sub_zero", 5'b00110, 9, 9, 0, 1'b1));
    tbl.push_back(mkSimple("slt_neg", 5'b00101, 32'hFFFF_FFFF, 1, 1, 1'b0));
    tbl.push_back(mkSimple("slt_false", 5'b00101, 5, 32'hFFFF_FFFD, 0, 1'b1));
    tbl.push_back(mkSimple("add_wrap", 5'b00010, 32'hFFFF_FFFF, 1, 0, 1'b1));
    tbl.push_back(mkSimple("nor", 5'b00100, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0));
    tbl.push_back(mkSimple("and", 5'b00000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0));
    tbl.push_back(mkSimple("sub_neg", 5'b00110, 3, 5, 32'hFFFF_FFFE, 1'b0));
    tbl.push_back(mkv("mul_nowb", 2'b01, 2'b01, 5'b00111, 7, 6, 0, 5'd1, 5'd2, 5'd3,
                      1'b0, 5'd0, 0, 1'b0, 5'd0, 0, 0, 6, 5'd2, 1'b1));

    s = '0;
    applyStimulus(s);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkRegs("reset", '0);
    checkOutput("reset/ex_stall", 64'(ex_stall), 64'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].in);
      #1;
      checkOutput({tbl[i].name, "/ex_stall"}, 64'(ex_stall), 64'd0);
      @(negedge clk);
      checkRegs(tbl[i].name, tbl[i].exp);
    end

    for (int i = 0; i < 200; i++) begin
      s = randIn();
      applyStimulus(s);
      e = model(s);
      #1;
      checkOutput($sformatf("rand%0d/ex_stall", i), 64'(ex_stall), 64'd0);
      @(negedge clk);
      checkRegs($sformatf("rand%0d", i), e);
    end

    // Reset in the middle of ordinary traffic.
    s = '0;
    s.wb = 2'b11; s.m = 2'b10; s.ex = 5'b10010; s.src_a = 40; s.src_b = 2; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd6;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("traffic/pre_reset", 64'(MEM_ALU_OUT), 64'd42);
    rst = 1'b0;
    @(negedge clk);
    checkRegs("traffic_reset", '0);
    checkOutput("traffic_reset/ex_stall", 64'(ex_stall), 64'd0);
    rst = 1'b1;

`ifdef EX_MUL_EN
    runMul("mul_7x6", 7, 6, 42);
    runMul("mul_wrap", 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);

    // Reset while the multiplier is stepping, then a plain ADD.
    s = '0;
    s.wb = 2'b10; s.ex = 5'b10111; s.src_a = 7; s.src_b = 6; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd12;
    applyStimulus(s);
    repeat ((N_STEPS >= 16) ? 10 : N_STEPS / 2) @(negedge clk);
    checkOutput("mul_abort/stalling", 64'(ex_stall), 64'd1);
    s.ex = 5'b10010; s.src_a = 2; s.src_b = 3; s.rd = 5'd5;
    applyStimulus(s);
    rst = 1'b0;
    @(negedge clk);
    checkRegs("mul_abort_reset", '0);
    checkOutput("mul_abort/ex_stall", 64'(ex_stall), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("mul_abort/ex_stall_after", 64'(ex_stall), 64'd0);
    @(negedge clk);
    checkRegs("mul_abort_add", '{wb: 2'b10, m: 2'b00, alu_out: 5, wr_data: 3, rd: 5'd5, zero: 1'b0});
`else
    // Without the multiplier, MUL is a one-cycle op that yields 0 and never stalls.
    s = '0;
    s.wb = 2'b10; s.ex = 5'b10111; s.src_a = 7; s.src_b = 6; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd12;
    applyStimulus(s);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("mul_off/ex_stall%0d", c), 64'(ex_stall), 64'd0);
      @(negedge clk);
      checkRegs($sformatf("mul_off%0d", c), '{wb: 2'b10, m: 2'b00, alu_out: 0, wr_data: 6, rd: 5'd12, zero: 1'b1});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
